// File: rtl/mm_game_pkg.sv
// Shared game definitions: sequencer states, player encoding and default game sizes.
package mm_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAKE_CODE,
        ST_GUESS,
        ST_ROUND_END,
        ST_GAME_OVER
    } game_state_t;

    localparam logic PLAYER_A = 1'b1;
    localparam logic PLAYER_B = 1'b0;

    localparam int unsigned DEF_MAX_GUESSES = 8;
    localparam int unsigned DEF_ROUNDS      = 4;
    localparam int unsigned DEF_SCORE_W     = 6;
    localparam int unsigned COUNT_W         = 4;
    localparam int unsigned AMOUNT_W        = COUNT_W + 1;

    // Maker alternates A,B,A,B... starting with A in round 0.
    function automatic logic maker_of(input logic [COUNT_W-1:0] round);
        return round[0] ? PLAYER_B : PLAYER_A;
    endfunction

endpackage

// File: rtl/mm_turn_controller_if.sv
// Event inputs and game-status outputs of the turn controller.
interface mm_turn_controller_if #(
    parameter int unsigned SCORE_W = 6
);
    logic               start_btn;
    logic               code_entered;
    logic               guess_entered;
    logic               guess_correct;
    logic               started;
    logic               active_p;
    logic               take_code;
    logic [3:0]         guess_count;
    logic [3:0]         round_num;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic               round_over;
    logic               game_over;
    logic               winner_a;
    logic               winner_b;

    modport master (
        output start_btn, code_entered, guess_entered, guess_correct,
        input  started, active_p, take_code, guess_count, round_num,
               score_a, score_b, round_over, game_over, winner_a, winner_b
    );

    modport slave (
        input  start_btn, code_entered, guess_entered, guess_correct,
        output started, active_p, take_code, guess_count, round_num,
               score_a, score_b, round_over, game_over, winner_a, winner_b
    );
endinterface

// File: rtl/mm_score_keeper.sv
// Two saturating score accumulators plus the registered end-of-game winner compare.
module mm_score_keeper
    import mm_game_pkg::*;
#(
    parameter int unsigned SCORE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                add_en,
    input  logic                sel,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                eval,
    output logic [SCORE_W-1:0]  score_a,
    output logic [SCORE_W-1:0]  score_b,
    output logic                winner_a,
    output logic                winner_b
);
    localparam int unsigned SUM_W = SCORE_W + AMOUNT_W;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [SCORE_W-1:0] sel_score;
    logic [SUM_W-1:0]   sum;
    logic [SCORE_W-1:0] sat_sum;
    logic [SCORE_W-1:0] next_a;
    logic [SCORE_W-1:0] next_b;

    always_comb begin
        sel_score = (sel == PLAYER_A) ? score_a : score_b;
        sum       = SUM_W'(sel_score) + SUM_W'(amount);
        sat_sum   = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
        next_a    = (add_en && sel == PLAYER_A) ? sat_sum : score_a;
        next_b    = (add_en && sel == PLAYER_B) ? sat_sum : score_b;
    end

    // Winner flags use the post-add scores so they are valid on the first GAME_OVER cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            score_a  <= '0;
            score_b  <= '0;
            winner_a <= 1'b0;
            winner_b <= 1'b0;
        end else begin
            score_a <= next_a;
            score_b <= next_b;
            if (eval) begin
                winner_a <= (next_a >= next_b);
                winner_b <= (next_b >= next_a);
            end
        end
    end

endmodule

// File: rtl/mm_turn_controller.sv
// Game-flow sequencer feeding the role decoder: phases, guess/round counting and scoring.
module mm_turn_controller
    import mm_game_pkg::*;
#(
    parameter int unsigned MAX_GUESSES = DEF_MAX_GUESSES,
    parameter int unsigned ROUNDS      = DEF_ROUNDS,
    parameter int unsigned SCORE_W     = DEF_SCORE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    mm_turn_controller_if.slave  bus
);
    game_state_t        state;
    logic               solved;
    logic [COUNT_W-1:0] guess_count;
    logic [COUNT_W-1:0] round_num;
    logic               started;
    logic               active_p;
    logic               take_code;
    logic               round_over;
    logic               game_over;

    logic [COUNT_W-1:0]  gc_inc;
    logic [COUNT_W-1:0]  rn_inc;
    logic                last_round;
    logic                new_game;
    logic                add_en;
    logic [AMOUNT_W-1:0] amount;

    always_comb begin
        gc_inc     = guess_count + COUNT_W'(1);
        rn_inc     = round_num + COUNT_W'(1);
        last_round = (rn_inc == COUNT_W'(ROUNDS));
        new_game   = bus.start_btn && (state == ST_IDLE || state == ST_GAME_OVER);
        add_en     = (state == ST_ROUND_END);
        amount     = AMOUNT_W'(guess_count) + AMOUNT_W'(!solved);
    end

    mm_score_keeper #(.SCORE_W(SCORE_W)) u_score (
        .clk      (clk),
        .reset    (reset),
        .clear    (new_game),
        .add_en   (add_en),
        .sel      (maker_of(round_num)),
        .amount   (amount),
        .eval     (add_en && last_round),
        .score_a  (bus.score_a),
        .score_b  (bus.score_b),
        .winner_a (bus.winner_a),
        .winner_b (bus.winner_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            solved      <= 1'b0;
            guess_count <= '0;
            round_num   <= '0;
            started     <= 1'b0;
            active_p    <= 1'b0;
            take_code   <= 1'b0;
            round_over  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            round_over <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start_btn) begin
                        state       <= ST_TAKE_CODE;
                        started     <= 1'b1;
                        take_code   <= 1'b1;
                        active_p    <= PLAYER_A;
                        round_num   <= '0;
                        guess_count <= '0;
                        solved      <= 1'b0;
                        game_over   <= 1'b0;
                    end
                end
                ST_TAKE_CODE: begin
                    if (bus.code_entered) begin
                        state     <= ST_GUESS;
                        take_code <= 1'b0;
                        active_p  <= ~maker_of(round_num);
                    end
                end
                ST_GUESS: begin
                    if (bus.guess_entered) begin
                        guess_count <= gc_inc;
                        solved      <= bus.guess_correct;
                        if (bus.guess_correct || gc_inc == COUNT_W'(MAX_GUESSES)) begin
                            state      <= ST_ROUND_END;
                            round_over <= 1'b1;
                        end
                    end
                end
                ST_ROUND_END: begin
                    guess_count <= '0;
                    solved      <= 1'b0;
                    round_num   <= rn_inc;
                    if (last_round) begin
                        state     <= ST_GAME_OVER;
                        started   <= 1'b0;
                        take_code <= 1'b0;
                        active_p  <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        state     <= ST_TAKE_CODE;
                        take_code <= 1'b1;
                        active_p  <= maker_of(rn_inc);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.started     = started;
    assign bus.active_p    = active_p;
    assign bus.take_code   = take_code;
    assign bus.guess_count = guess_count;
    assign bus.round_num   = round_num;
    assign bus.round_over  = round_over;
    assign bus.game_over   = game_over;

endmodule

// File: tb/tb_mm_turn_controller.sv
// Directed bench: full 4-round game, ignore cases, mid-game reset and score saturation.
module tb_mm_turn_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mm_turn_controller_if #(.SCORE_W(6)) bus1 ();
    mm_turn_controller_if #(.SCORE_W(3)) bus2 ();

    mm_turn_controller #(.MAX_GUESSES(8), .ROUNDS(4), .SCORE_W(6)) dut (
        .clk (clk), .reset (reset), .bus (bus1.slave)
    );

    mm_turn_controller #(.MAX_GUESSES(8), .ROUNDS(4), .SCORE_W(3)) dut_sat (
        .clk (clk), .reset (reset), .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic c, input logic g, input logic gc);
        bus1.start_btn = s; bus1.code_entered = c; bus1.guess_entered = g; bus1.guess_correct = gc;
        bus2.start_btn = s; bus2.code_entered = c; bus2.guess_entered = g; bus2.guess_correct = gc;
    endtask

    // Hold inputs for one active edge, then release and settle away from the edge.
    task automatic pulse(input logic s, input logic c, input logic g, input logic gc);
        drive(s, c, g, gc);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic guesses(input int n_wrong, input logic last_correct);
        for (int i = 0; i < n_wrong; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        if (last_correct) pulse(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic chk_phase(input string tag, input logic st, input logic ap, input logic tc,
                             input logic [3:0] gcnt, input logic [3:0] rnd);
        chk({tag, ".started"},     32'(bus1.started),     32'(st));
        chk({tag, ".active_p"},    32'(bus1.active_p),    32'(ap));
        chk({tag, ".take_code"},   32'(bus1.take_code),   32'(tc));
        chk({tag, ".guess_count"}, 32'(bus1.guess_count), 32'(gcnt));
        chk({tag, ".round_num"},   32'(bus1.round_num),   32'(rnd));
    endtask

    task automatic chk_scores(input string tag, input logic [5:0] a, input logic [5:0] b,
                              input logic [2:0] sa, input logic [2:0] sb);
        chk({tag, ".score_a"},     32'(bus1.score_a), 32'(a));
        chk({tag, ".score_b"},     32'(bus1.score_b), 32'(b));
        chk({tag, ".sat_score_a"}, 32'(bus2.score_a), 32'(sa));
        chk({tag, ".sat_score_b"}, 32'(bus2.score_b), 32'(sb));
    endtask

    task automatic chk_end(input string tag, input logic ro, input logic go,
                           input logic wa, input logic wb);
        chk({tag, ".round_over"}, 32'(bus1.round_over), 32'(ro));
        chk({tag, ".game_over"},  32'(bus1.game_over),  32'(go));
        chk({tag, ".winner_a"},   32'(bus1.winner_a),   32'(wa));
        chk({tag, ".winner_b"},   32'(bus1.winner_b),   32'(wb));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_phase("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_end("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_scores("reset", 6'd0, 6'd0, 3'd0, 3'd0);
        reset = 1'b0;

        // Events other than start are ignored in IDLE.
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        chk_phase("idle_ignore", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_phase("start", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
        chk_end("start", 1'b0, 1'b0, 1'b0, 1'b0);

        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        chk_phase("guess_in_take_code", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_phase("start_mid_game", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);

        // Round 0: A makes, B breaks, solved on the 3rd guess.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_phase("r0_code", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_phase("code_in_guess", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk_phase("correct_no_guess", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_phase("r0_g1", 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk_phase("r0_g2", 1'b1, 1'b0, 1'b0, 4'd2, 4'd0);
        chk("r0_g2.round_over", 32'(bus1.round_over), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        chk_phase("r0_g3", 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        chk("r0_g3.round_over", 32'(bus1.round_over), 32'd1);
        idle_cycle();
        chk_phase("r1_take", 1'b1, 1'b0, 1'b1, 4'd0, 4'd1);
        chk("r1_take.round_over", 32'(bus1.round_over), 32'd0);
        chk_scores("r0_end", 6'd3, 6'd0, 3'd3, 3'd0);

        // Round 1: B makes, A breaks, 8 wrong guesses.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_phase("r1_code", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
        guesses(7, 1'b0);
        chk_phase("r1_g7", 1'b1, 1'b1, 1'b0, 4'd7, 4'd1);
        chk("r1_g7.round_over", 32'(bus1.round_over), 32'd0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk_phase("r1_g8", 1'b1, 1'b1, 1'b0, 4'd8, 4'd1);
        chk("r1_g8.round_over", 32'(bus1.round_over), 32'd1);
        idle_cycle();
        chk_phase("r2_take", 1'b1, 1'b1, 1'b1, 4'd0, 4'd2);
        chk_scores("r1_end", 6'd3, 6'd9, 3'd3, 3'd7);

        // Round 2: A makes, solved on the 5th guess.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        guesses(4, 1'b1);
        chk_phase("r2_g5", 1'b1, 1'b0, 1'b0, 4'd5, 4'd2);
        idle_cycle();
        chk_phase("r3_take", 1'b1, 1'b0, 1'b1, 4'd0, 4'd3);
        chk_scores("r2_end", 6'd8, 6'd9, 3'd7, 3'd7);

        // Round 3: B makes, solved on the 2nd guess; game ends.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_phase("r3_code", 1'b1, 1'b1, 1'b0, 4'd0, 4'd3);
        guesses(1, 1'b1);
        chk("r3_g2.round_over", 32'(bus1.round_over), 32'd1);
        chk("r3_g2.game_over", 32'(bus1.game_over), 32'd0);
        idle_cycle();
        chk_phase("game_over", 1'b0, 1'b0, 1'b0, 4'd0, 4'd4);
        chk_end("game_over", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_scores("game_over", 6'd8, 6'd11, 3'd7, 3'd7);
        chk("tie.winner_a", 32'(bus2.winner_a), 32'd1);
        chk("tie.winner_b", 32'(bus2.winner_b), 32'd1);
        chk("tie.game_over", 32'(bus2.game_over), 32'd1);

        // GAME_OVER holds against non-start events.
        pulse(1'b0, 1'b1, 1'b1, 1'b1);
        idle_cycle();
        chk_phase("go_hold", 1'b0, 1'b0, 1'b0, 4'd0, 4'd4);
        chk_end("go_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        chk_scores("go_hold", 6'd8, 6'd11, 3'd7, 3'd7);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_phase("restart", 1'b1, 1'b1, 1'b1, 4'd0, 4'd0);
        chk_end("restart", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_scores("restart", 6'd0, 6'd0, 3'd0, 3'd0);

        // Reset in GUESS with five guesses counted, a guess pulse in the same cycle.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        guesses(5, 1'b0);
        chk_phase("pre_reset", 1'b1, 1'b0, 1'b0, 4'd5, 4'd0);
        reset = 1'b1;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        chk_phase("mid_reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_end("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_scores("mid_reset", 6'd0, 6'd0, 3'd0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mm_turn_controller.md
Name: mm_turn_controller

Overview:
- Game-flow sequencer directly upstream of the active-player/role decoder.
- Produces that decoder's `started`, `active_p` and `take_code` inputs from start, code-entry and guess-submission events.
- Counts guesses per round, swaps the code-maker every round, keeps both players' scores and flags game end and winner.

Parameters:
- MAX_GUESSES, 8, guesses allowed to the breaker per round (2..15).
- ROUNDS, 4, rounds per game; maker alternates A,B,A,B... starting with A (1..15).
- SCORE_W, 6, width of each player's score register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_btn  in  1  one-cycle pulse; starts a game from IDLE or GAME_OVER
- code_entered  in  1  one-cycle pulse; code-maker has confirmed the secret code
- guess_entered  in  1  one-cycle pulse; breaker has submitted a guess
- guess_correct  in  1  comparator verdict; qualified by guess_entered in the same cycle
- started  out  1  1 while a game is in progress (TAKE_CODE, GUESS, ROUND_END)
- active_p  out  1  1 = player A acting, 0 = player B acting
- take_code  out  1  1 in code-entry phase, 0 in guessing phase
- guess_count  out  4  guesses accepted in the current round
- round_num  out  4  current round index, 0-based
- score_a  out  SCORE_W  player A score
- score_b  out  SCORE_W  player B score
- round_over  out  1  one-cycle pulse when a round closes
- game_over  out  1  1 while in GAME_OVER
- winner_a  out  1  valid when game_over=1; set on A win or tie
- winner_b  out  1  valid when game_over=1; set on B win or tie

Behaviour:
- All outputs are registered; no combinational input-to-output path.
- Reset (sync, active-high, priority over all inputs): state=IDLE; every output and internal register = 0.
- States: IDLE, TAKE_CODE, GUESS, ROUND_END, GAME_OVER.
- Maker for round r: A if r even, B if r odd. Breaker is the other player.
- IDLE:
  - start_btn -> TAKE_CODE; round_num=0; scores=0; guess_count=0.
  - All other inputs ignored.
- TAKE_CODE: started=1, take_code=1, active_p=maker.
  - code_entered -> GUESS next cycle.
  - guess_entered ignored.
- GUESS: started=1, take_code=0, active_p=breaker.
  - On guess_entered: guess_count += 1, solved = guess_correct.
  - If guess_correct=1 or the new count equals MAX_GUESSES -> ROUND_END.
  - code_entered ignored.
  - guess_correct with guess_entered=0 is ignored.
- ROUND_END (exactly 1 cycle): round_over=1; started=1; active_p and take_code hold their GUESS values.
  - Maker score += guess_count + (solved ? 0 : 1).
  - Score saturates at 2^SCORE_W-1 (no wrap).
  - Then guess_count=0, solved=0, round_num += 1.
  - If the new round_num equals ROUNDS -> GAME_OVER; else -> TAKE_CODE with the maker swapped.
- GAME_OVER: started=0, take_code=0, active_p=0, game_over=1.
  - Scores and round_num hold.
  - winner_a = (score_a >= score_b); winner_b = (score_b >= score_a).
  - start_btn -> TAKE_CODE with a fresh game: scores, round_num, guess_count, winner flags cleared.
- start_btn in TAKE_CODE, GUESS or ROUND_END is ignored; only reset aborts a game.
- Event pulses arriving in the same cycle as reset are dropped.
- Latency: each accepted event changes outputs on the following clk edge.

Decomposition:
- Shared package mm_game_pkg holds:
  - the state enum (IDLE, TAKE_CODE, GUESS, ROUND_END, GAME_OVER);
  - PLAYER_A=1'b1 / PLAYER_B=1'b0 constants;
  - default MAX_GUESSES / ROUNDS values, shared with the comparator and display blocks.
- One natural sub-module, mm_score_keeper: two SCORE_W saturating accumulators with clear, add-enable, player select, and the winner compare.

Test Plan:
- Reset, then start_btn -> next cycle started=1, take_code=1, active_p=1, round_num=0, scores 0.
- Round 0: code_entered, then 3 guesses with correct on the 3rd -> take_code=0, active_p=0 during GUESS; guess_count 1,2,3; round_over pulse; score_a=3; round_num=1 with active_p=0, take_code=1.
- Round 1: 8 wrong guesses -> ROUND_END after the 8th; score_b=9; guess_count returns to 0.
- Full 4-round game: scores A=3+5=8, B=9+2=11 -> game_over=1, started=0, winner_a=0, winner_b=1. Equal scores -> both winner flags 1.
- Ignore checks:
  - guess_entered in TAKE_CODE: no count change.
  - code_entered in GUESS: no change.
  - start_btn mid-game: no change.
  - guess_correct without guess_entered: no change.
- Reset asserted in GUESS with guess_count=5 -> next cycle IDLE, all outputs 0. start_btn in GAME_OVER -> fresh game with scores cleared. Saturation: SCORE_W=3 with accumulated 9 -> score holds at 7.
